bcd_balance_sub: RTL and testbench

BCD_BALANCE_SUB -- requirements
Module: bcd_balance_sub

---
 rtl/bcd_balance_sub.sv | 130 +++++++++++++
 tb/tb_bcd_balance_sub.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_balance_sub.sv
// Packed-BCD balance register with serial digit-by-digit subtract, one digit per clock.
// Subtract completes DIGITS edges after start is taken; start/load are ignored while busy.
module bcd_balance_sub #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                start,
   input  logic [4*DIGITS-1:0] sub_val,
   output logic [4*DIGITS-1:0] balance,
   output logic                busy,
   output logic                done,
   output logic                insufficient,
   output logic                err
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic [W-1:0]      work, work_nxt, sub;
   logic [IW-1:0]     idx;
   logic              borrow, borrow_nxt, last;
   logic [3:0]        wd, sd, rdig;
   logic signed [4:0] diff;
   logic              load_ok, start_ok;

   function automatic logic is_bcd(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   assign load_ok  = is_bcd(load_val);
   assign start_ok = is_bcd(sub_val);
   assign last     = (idx == IW'(DIGITS - 1));

   // Current digit: signed 5-bit difference, corrected back into 0..9 on borrow
   always_comb begin
      wd = '0;
      sd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            wd = work[4*i +: 4];
            sd = sub[4*i +: 4];
         end
      end
      diff       = $signed({1'b0, wd}) - $signed({1'b0, sd}) - $signed({4'b0000, borrow});
      borrow_nxt = diff[4];
      rdig       = borrow_nxt ? 4'(diff + 5'sd10) : diff[3:0];
      work_nxt   = work;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) work_nxt[4*i +: 4] = rdig;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!clear && !load && start && start_ok) state_nxt = RUN;
         RUN:  if (clear || last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         balance      <= '0;
         work         <= '0;
         sub          <= '0;
         idx          <= '0;
         borrow       <= 1'b0;
         done         <= 1'b0;
         insufficient <= 1'b0;
         err          <= 1'b0;
      end else begin
         done         <= 1'b0;
         insufficient <= 1'b0;
         err          <= 1'b0;
         if (clear) begin
            balance <= '0;
            work    <= '0;
            idx     <= '0;
            borrow  <= 1'b0;
         end else if (state == IDLE) begin
            if (load) begin
               if (load_ok) balance <= load_val;
               else         err     <= 1'b1;
            end else if (start) begin
               if (start_ok) begin
                  sub    <= sub_val;
                  work   <= balance;
                  idx    <= '0;
                  borrow <= 1'b0;
               end else begin
                  err <= 1'b1;
               end
            end
         end else begin
            work   <= work_nxt;
            borrow <= borrow_nxt;
            idx    <= idx + IW'(1);
            if (last) begin
               done <= 1'b1;
               // A final borrow means the subtrahend was larger: keep the old balance
               if (borrow_nxt) insufficient <= 1'b1;
               else            balance      <= work_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_balance_sub.sv
// Bench for bcd_balance_sub: vector table through a done/err scoreboard,
// plus hand sequences for busy-time requests, clear mid-run and reset mid-run.
module tb_bcd_balance_sub;

   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_val = '0;
   logic        start = 1'b0;
   logic [15:0] sub_val = '0;
   logic [15:0] balance;
   logic        busy, done, insufficient, err;

   bcd_balance_sub #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .start(start), .sub_val(sub_val), .balance(balance), .busy(busy),
      .done(done), .insufficient(insufficient), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_err;
      logic        ins;
      logic [15:0] bal;
      int          cyc;
   } exp_t;

   typedef struct {
      bit          is_sub;
      logic [15:0] val;
      logic [15:0] bal;
      bit          ins;
      bit          err;
   } vec_t;

   exp_t sbq[$];
   exp_t mon_e;
   vec_t vecs[16];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   logic prev_done = 1'b0, prev_err = 1'b0, prev_ins = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard side: every done/err pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (done || err) begin
            if (sbq.size() == 0) begin
               check("unexpected_event", {30'b0, done, err}, 32'd0);
            end else begin
               mon_e = sbq.pop_front();
               check("event_kind", {30'b0, done, err}, mon_e.is_err ? 32'd1 : 32'd2);
               check("insufficient", {31'b0, insufficient}, {31'b0, mon_e.ins});
               check("event_balance", {16'b0, balance}, {16'b0, mon_e.bal});
               check("event_latency", cyc, mon_e.cyc);
            end
         end
         if (insufficient && !done) check("ins_without_done", 32'd1, 32'd0);
         if ((done && prev_done) || (err && prev_err) || (insufficient && prev_ins))
            check("pulse_width", {29'b0, done, err, insufficient}, 32'd0);
      end
      prev_done = done;
      prev_err  = err;
      prev_ins  = insufficient;
   end

   task automatic push_exp(input logic is_err, input logic ins, input logic [15:0] bal);
      exp_t e;
      e.is_err = is_err;
      e.ins    = ins;
      e.bal    = bal;
      e.cyc    = cyc + 1 + (is_err ? 0 : DIGITS);
      sbq.push_back(e);
   endtask

   task automatic drain(input string name, output int busy_cycles);
      int n;
      n = 0;
      busy_cycles = 0;
      while (sbq.size() != 0 && n < DIGITS + 8) begin
         if (busy) busy_cycles++;
         tick();
         n++;
      end
      if (sbq.size() != 0) begin
         check({name, "_timeout"}, sbq.size(), 32'd0);
         sbq.delete();
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1;
      load_val = v;
      tick();
      load = 1'b0;
   endtask

   int bc;
   int saved;

   initial begin
      vecs[0]  = '{0, 16'h0250, 16'h0250, 0, 0};
      vecs[1]  = '{1, 16'h0075, 16'h0175, 0, 0};
      vecs[2]  = '{1, 16'h0200, 16'h0175, 1, 0};
      vecs[3]  = '{0, 16'h1000, 16'h1000, 0, 0};
      vecs[4]  = '{1, 16'h0001, 16'h0999, 0, 0};
      vecs[5]  = '{1, 16'h0999, 16'h0000, 0, 0};
      vecs[6]  = '{0, 16'h9999, 16'h9999, 0, 0};
      vecs[7]  = '{1, 16'h00A5, 16'h9999, 0, 1};
      vecs[8]  = '{0, 16'h3F00, 16'h9999, 0, 1};
      vecs[9]  = '{1, 16'h1234, 16'h8765, 0, 0};
      vecs[10] = '{1, 16'h8765, 16'h0000, 0, 0};
      vecs[11] = '{1, 16'h0000, 16'h0000, 0, 0};
      vecs[12] = '{1, 16'h0001, 16'h0000, 1, 0};
      vecs[13] = '{0, 16'h4321, 16'h4321, 0, 0};
      vecs[14] = '{1, 16'h4322, 16'h4321, 1, 0};
      vecs[15] = '{1, 16'h0321, 16'h4000, 0, 0};

      #1 rst = 1'b1;
      #1;
      check("reset_balance", {16'b0, balance}, 32'd0);
      check("reset_flags", {28'b0, busy, done, insufficient, err}, 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].is_sub) begin
            start = 1'b1;
            sub_val = vecs[i].val;
            push_exp(vecs[i].err, vecs[i].ins, vecs[i].bal);
            tick();
            start = 1'b0;
            drain($sformatf("vec%0d", i), bc);
            check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].err ? 32'd0 : DIGITS);
         end else begin
            if (vecs[i].err) push_exp(1'b1, 1'b0, vecs[i].bal);
            do_load(vecs[i].val);
            drain($sformatf("vec%0d", i), bc);
         end
         check($sformatf("vec%0d_balance", i), {16'b0, balance}, {16'b0, vecs[i].bal});
      end

      // Requests while busy are ignored and balance holds until completion
      do_load(16'h0250);
      saved = done_cnt;
      start = 1'b1;
      sub_val = 16'h0075;
      push_exp(1'b0, 1'b0, 16'h0175);
      tick();
      sub_val = 16'h0100;
      load = 1'b1;
      load_val = 16'h5555;
      tick();
      check("run_balance_stable", {16'b0, balance}, 32'h0250);
      tick();
      start = 1'b0;
      load = 1'b0;
      drain("busy_ignore", bc);
      repeat (6) tick();
      check("busy_ignore_balance", {16'b0, balance}, 32'h0175);
      check("busy_ignore_done_count", done_cnt - saved, 32'd1);

      // clear two cycles into RUN aborts with no done
      saved = done_cnt;
      start = 1'b1;
      sub_val = 16'h0075;
      tick();
      start = 1'b0;
      tick();
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_balance", {16'b0, balance}, 32'd0);
      check("clear_busy", {31'b0, busy}, 32'd0);
      repeat (8) tick();
      check("clear_no_done", done_cnt - saved, 32'd0);

      // Asynchronous reset mid-RUN, between edges
      do_load(16'h1000);
      saved = done_cnt;
      start = 1'b1;
      sub_val = 16'h0001;
      tick();
      start = 1'b0;
      tick();
      #3 rst = 1'b1;
      #1;
      check("async_rst_balance", {16'b0, balance}, 32'd0);
      check("async_rst_busy", {31'b0, busy}, 32'd0);
      sbq.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      do_load(16'h0042);
      check("first_op_after_rst", {16'b0, balance}, 32'h0042);
      repeat (8) tick();
      check("rst_no_done", done_cnt - saved, 32'd0);
      check("final_queue_empty", sbq.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
